bsg_wrr_n_to_1: RTL and testbench



---
 rtl/bsg_wrr_pkg.sv | 18 +
 rtl/bsg_wrr_n_to_1_if.sv | 32 +++
 rtl/bsg_wrr_rotate_pick.sv | 34 +++
 rtl/bsg_wrr_n_to_1.sv | 114 +++++++++++
 tb/tb_bsg_wrr_n_to_1.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bsg_wrr_pkg.sv
// Shared types and helpers for the weighted round-robin concentrator.
// Config fields are 8 bits wide, so num_in_p <= 256 and weight_width_p <= 8.
package bsg_wrr_pkg;

  localparam int unsigned WeightWidthDefault = 4;
  localparam int unsigned CfgIdxWidth        = 8;
  localparam int unsigned CfgWeightWidth     = 8;

  typedef struct packed {
    logic [CfgIdxWidth-1:0]    idx;
    logic [CfgWeightWidth-1:0] weight;
  } wrr_cfg_t;

  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_wrr_n_to_1_if.sv
// Bundles the input side, output side and weight-config signals of bsg_wrr_n_to_1.
interface bsg_wrr_n_to_1_if
  import bsg_wrr_pkg::*;
#(
  parameter int unsigned width_p        = 16,
  parameter int unsigned num_in_p       = 2,
  parameter int unsigned weight_width_p = WeightWidthDefault
);
  localparam int unsigned tag_width_lp = tag_width(num_in_p);

  logic [num_in_p*width_p-1:0] data_i;
  logic [num_in_p-1:0]         v_i;
  logic [num_in_p-1:0]         yumi_o;
  logic                        v_o;
  logic [width_p-1:0]          data_o;
  logic [tag_width_lp-1:0]     tag_o;
  logic                        yumi_i;
  logic                        cfg_v_i;
  logic [tag_width_lp-1:0]     cfg_idx_i;
  logic [weight_width_p-1:0]   cfg_weight_i;

  modport slave (
    input  data_i, v_i, yumi_i, cfg_v_i, cfg_idx_i, cfg_weight_i,
    output yumi_o, v_o, data_o, tag_o
  );

  modport master (
    output data_i, v_i, yumi_i, cfg_v_i, cfg_idx_i, cfg_weight_i,
    input  yumi_o, v_o, data_o, tag_o
  );

endinterface

// File: rtl/bsg_wrr_rotate_pick.sv
// Rotating-priority first-one finder: scans start_i, start_i+1, ... modulo num_in_p.
module bsg_wrr_rotate_pick
  import bsg_wrr_pkg::*;
#(
  parameter int unsigned num_in_p = 2,
  localparam int unsigned tag_width_lp = tag_width(num_in_p)
) (
  input  logic [num_in_p-1:0]     elig_i,
  input  logic [tag_width_lp-1:0] start_i,
  output logic [num_in_p-1:0]     one_hot_o,
  output logic [tag_width_lp-1:0] idx_o,
  output logic                    found_o
);

  logic [tag_width_lp-1:0] pos;

  // Walk from the farthest offset down so the nearest eligible input wins last.
  always_comb begin
    one_hot_o = '0;
    idx_o     = '0;
    found_o   = 1'b0;
    pos       = '0;
    for (int i = int'(num_in_p) - 1; i >= 0; i--) begin
      pos = tag_width_lp'((int'(start_i) + i) % int'(num_in_p));
      if (elig_i[pos]) begin
        one_hot_o      = '0;
        one_hot_o[pos] = 1'b1;
        idx_o          = pos;
        found_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_wrr_n_to_1.sv
// Weighted round-robin N-to-1 concentrator: a winner keeps the grant for up to
// weight[k] accepted beats while valid, then priority rotates past it.
module bsg_wrr_n_to_1
  import bsg_wrr_pkg::*;
#(
  parameter int unsigned width_p        = 16,
  parameter int unsigned num_in_p       = 2,
  parameter int unsigned weight_width_p = WeightWidthDefault
) (
  input logic              clk_i,
  input logic              reset_i,
  bsg_wrr_n_to_1_if.slave  bus_io
);

  localparam int unsigned tag_width_lp = tag_width(num_in_p);

  typedef logic [tag_width_lp-1:0]   tag_t;
  typedef logic [weight_width_p-1:0] wt_t;

  tag_t                   owner_q, owner_d;
  logic                   lock_q, lock_d;
  wt_t                    cnt_q, cnt_d;
  wt_t [num_in_p-1:0]     weight_q, weight_d;

  logic [num_in_p-1:0]    elig, pick_oh, sel_oh;
  tag_t                   start, pick_idx, sel;
  logic                   pick_found, hold, accept;
  wt_t                    cnt_new;
  logic [width_p-1:0]     data_sel;
  wrr_cfg_t               cfg;

  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < num_in_p; k++) begin
      elig[k] = bus_io.v_i[k] & (weight_q[k] != '0);
    end
  end

  assign start = (owner_q == tag_t'(num_in_p - 1)) ? '0 : owner_q + tag_t'(1);
  assign hold  = lock_q & elig[owner_q] & (cnt_q < weight_q[owner_q]);

  bsg_wrr_rotate_pick #(
    .num_in_p (num_in_p)
  ) u_pick (
    .elig_i    (elig),
    .start_i   (start),
    .one_hot_o (pick_oh),
    .idx_o     (pick_idx),
    .found_o   (pick_found)
  );

  always_comb begin
    sel_oh = pick_oh;
    if (hold) begin
      sel_oh          = '0;
      sel_oh[owner_q] = 1'b1;
    end
  end

  assign sel = hold ? owner_q : pick_idx;

  // One-hot AND-OR mux; an all-zero select yields zero data when nothing is valid.
  always_comb begin
    data_sel = '0;
    for (int unsigned k = 0; k < num_in_p; k++) begin
      data_sel |= {width_p{sel_oh[k]}} & bus_io.data_i[k*width_p +: width_p];
    end
  end

  assign accept        = bus_io.yumi_i & pick_found & ~reset_i;
  assign bus_io.v_o    = pick_found;
  assign bus_io.tag_o  = sel;
  assign bus_io.data_o = data_sel;
  assign bus_io.yumi_o = accept ? sel_oh : '0;

  assign cfg = '{idx:    CfgIdxWidth'(bus_io.cfg_idx_i),
                 weight: CfgWeightWidth'(bus_io.cfg_weight_i)};

  always_comb begin
    cnt_new  = hold ? cnt_q + wt_t'(1) : wt_t'(1);
    owner_d  = owner_q;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    if (accept) begin
      owner_d = sel;
      cnt_d   = cnt_new;
      // Burst completion is judged against the weight in force this cycle.
      lock_d  = (cnt_new != weight_q[sel]);
    end
    for (int unsigned k = 0; k < num_in_p; k++) begin
      if (bus_io.cfg_v_i && (cfg.idx == CfgIdxWidth'(k))) begin
        weight_d[k] = wt_t'(cfg.weight);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q <= tag_t'(num_in_p - 1);
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      for (int unsigned k = 0; k < num_in_p; k++) begin
        weight_q[k] <= wt_t'(1);
      end
    end else begin
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
    end
  end

endmodule

// File: tb/tb_bsg_wrr_n_to_1.sv
// Directed and randomized checks of bsg_wrr_n_to_1 against an arbitration-rule model.
module tb_bsg_wrr_n_to_1;
  import bsg_wrr_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned WW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsg_wrr_n_to_1_if #(.width_p(W), .num_in_p(N), .weight_width_p(WW)) bus ();

  bsg_wrr_n_to_1 #(
    .width_p        (W),
    .num_in_p       (N),
    .weight_width_p (WW)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: who owns the grant, whether a burst is open, beats taken, weights.
  int m_owner;
  bit m_lock;
  int m_cnt;
  int m_w[N];

  bit             e_hold;
  logic           e_v;
  int             e_tag;
  logic [W-1:0]   e_data;
  logic [N-1:0]   e_yumi;

  function automatic void model_reset();
    m_owner = N - 1;
    m_lock  = 1'b0;
    m_cnt   = 0;
    for (int k = 0; k < N; k++) m_w[k] = 1;
  endfunction

  function automatic void model_eval();
    bit el[N];
    bit found;
    for (int k = 0; k < N; k++) el[k] = bus.v_i[k] && (m_w[k] != 0);
    e_hold = m_lock && el[m_owner] && (m_cnt < m_w[m_owner]);
    e_v = 1'b0; e_tag = 0; e_data = '0; e_yumi = '0;
    found = 1'b0;
    if (e_hold) begin
      e_v = 1'b1; e_tag = m_owner;
    end else begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_owner + i) % N;
        if (!found && el[k]) begin
          found = 1'b1; e_v = 1'b1; e_tag = k;
        end
      end
    end
    if (e_v) begin
      e_data = bus.data_i[e_tag*W +: W];
      if (bus.yumi_i && !reset) e_yumi[e_tag] = 1'b1;
    end
  endfunction

  function automatic void model_update();
    if (reset) begin
      model_reset();
      return;
    end
    if (e_yumi != '0) begin
      if (e_hold) m_cnt = m_cnt + 1;
      else begin
        m_owner = e_tag; m_lock = 1'b1; m_cnt = 1;
      end
      if (m_cnt == m_w[e_tag]) m_lock = 1'b0;
    end
    if (bus.cfg_v_i && (int'(bus.cfg_idx_i) < N)) m_w[bus.cfg_idx_i] = int'(bus.cfg_weight_i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc(input int exp_tag = -1, input int exp_yumi = -1);
    @(negedge clk);
    model_eval();
    chk("v_o",    32'(bus.v_o),    32'(e_v));
    chk("tag_o",  32'(bus.tag_o),  32'(e_tag));
    chk("data_o", 32'(bus.data_o), 32'(e_data));
    chk("yumi_o", 32'(bus.yumi_o), 32'(e_yumi));
    if (exp_tag >= 0)  chk("tag_seq",  32'(bus.tag_o),  32'(exp_tag));
    if (exp_yumi >= 0) chk("yumi_seq", 32'(bus.yumi_o), 32'(exp_yumi));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cfg_write(input int idx, input int w);
    bus.v_i          = '0;
    bus.cfg_v_i      = 1'b1;
    bus.cfg_idx_i    = 2'(idx);
    bus.cfg_weight_i = WW'(w);
    cyc();
    bus.cfg_v_i      = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.v_i          = '0;
    bus.yumi_i       = 1'b0;
    bus.cfg_v_i      = 1'b0;
    bus.cfg_idx_i    = '0;
    bus.cfg_weight_i = '0;
    for (int k = 0; k < N; k++) bus.data_i[k*W +: W] = 16'hA000 + 16'(k);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Reset state: idle outputs, then a lone input 2 wins.
    cyc(0, 0);
    bus.v_i = 3'b100;
    cyc(2, 0);

    // Default weights alternate inputs 0 and 1.
    bus.v_i = 3'b011; bus.yumi_i = 1'b1;
    cyc(0, 1); cyc(1, 2); cyc(0, 1); cyc(1, 2);

    // Weighted bursts.
    cfg_write(0, 3);
    cfg_write(1, 1);
    bus.v_i = 3'b011; bus.yumi_i = 1'b1;
    cyc(0); cyc(0); cyc(0); cyc(1); cyc(0); cyc(0); cyc(0); cyc(1);

    // Owner drops after one beat, then gets a fresh burst.
    cyc(0);
    bus.v_i = 3'b010;
    cyc(1);
    bus.v_i = 3'b011;
    cyc(0); cyc(0); cyc(0); cyc(1);

    // Backpressure holds the grant without consuming quota.
    cfg_write(0, 2);
    bus.v_i = 3'b011; bus.yumi_i = 1'b0;
    repeat (5) cyc(0, 0);
    bus.yumi_i = 1'b1;
    cyc(0); cyc(0); cyc(1);

    // Disabled input is invisible; ignored out-of-range config index.
    cfg_write(1, 0);
    cfg_write(3, 0);
    bus.v_i = 3'b010;
    cyc(0, 0);
    chk("data_zero", 32'(bus.data_o), 32'd0);
    cfg_write(1, 1);
    cfg_write(0, 3);
    bus.v_i = 3'b011; bus.yumi_i = 1'b1;
    cyc(0);
    bus.cfg_v_i = 1'b1; bus.cfg_idx_i = 2'd0; bus.cfg_weight_i = 4'd1;
    cyc(0);
    bus.cfg_v_i = 1'b0;
    cyc(1);

    // Reset mid-burst.
    cfg_write(0, 3);
    bus.v_i = 3'b011; bus.yumi_i = 1'b1;
    cyc(0); cyc(0);
    reset = 1'b1;
    cyc(0, 0);
    reset = 1'b0;
    cyc(0); cyc(1); cyc(0);

    // Randomized traffic, config writes and occasional resets.
    for (int n = 0; n < 600; n++) begin
      bus.v_i          = 3'($urandom);
      bus.yumi_i       = ($urandom_range(0, 3) != 0);
      bus.data_i       = 48'({$urandom(), $urandom()});
      bus.cfg_v_i      = ($urandom_range(0, 7) == 0);
      bus.cfg_idx_i    = 2'($urandom_range(0, 3));
      bus.cfg_weight_i = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      reset            = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
